// File: rtl/sparse_dot_sequencer_if.sv
// A/B nonzero streams plus the shared mult/adder operand and result bus.
interface sparse_dot_sequencer_if #(
  parameter int unsigned IDX_W = 8
);
  logic             a_valid;
  logic             a_ready;
  logic [IDX_W-1:0] a_index;
  logic [15:0]      a_data;
  logic             a_last;

  logic             b_valid;
  logic             b_ready;
  logic [IDX_W-1:0] b_index;
  logic [15:0]      b_data;
  logic             b_last;

  logic             mul_en;
  logic [15:0]      mul_a;
  logic [15:0]      mul_b;
  logic [15:0]      mul_result;
  logic             mul_ovf;
  logic             mul_unf;
  logic             mul_nan;

  logic             add_en;
  logic [15:0]      add_a;
  logic [15:0]      add_b;
  logic [15:0]      add_result;
  logic             add_ovf;
  logic             add_unf;

  // Environment side: stream sources and the mult/adder instances.
  modport master (
    output a_valid, a_index, a_data, a_last,
    input  a_ready,
    output b_valid, b_index, b_data, b_last,
    input  b_ready,
    input  mul_en, mul_a, mul_b,
    output mul_result, mul_ovf, mul_unf, mul_nan,
    input  add_en, add_a, add_b,
    output add_result, add_ovf, add_unf
  );

  // Sequencer side.
  modport slave (
    input  a_valid, a_index, a_data, a_last,
    output a_ready,
    input  b_valid, b_index, b_data, b_last,
    output b_ready,
    output mul_en, mul_a, mul_b,
    input  mul_result, mul_ovf, mul_unf, mul_nan,
    output add_en, add_a, add_b,
    input  add_result, add_ovf, add_unf
  );
endinterface

// File: rtl/sparse_dot_sequencer.sv
// Merge-intersects two index-sorted sparse streams and accumulates matched products
// through the shared multiplier and adder, one product in flight at a time.
module sparse_dot_sequencer #(
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned ADD_LAT = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  a_empty,
  input  logic                  b_empty,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           result,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  nan,
  output logic                  zero,
  sparse_dot_sequencer_if.slave bus
);
  localparam int unsigned MaxLat = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 1);
  localparam logic [CntW-1:0] AddLoad = CntW'(ADD_LAT - 1);

  typedef enum logic [2:0] {StIdle, StMerge, StDrain, StMul, StAdd, StFin} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] a_idx, b_idx;
  logic             both_valid, a_lt, a_gt, idx_eq;
  logic             a_ready, b_ready, pop_a, pop_b;
  logic             a_done_q, b_done_q, a_done_n, b_done_n;
  logic             mul_en, add_en, last_lat;
  logic [CntW-1:0]  cnt_q;
  logic [15:0]      acc_q, prod_q, mul_a_q, mul_b_q, result_q;
  logic             ovf_s_q, unf_s_q, nan_s_q;
  logic             ovf_q, unf_q, nan_q, zero_q, done_q;

  assign a_idx      = bus.a_index;
  assign b_idx      = bus.b_index;
  assign both_valid = bus.a_valid & bus.b_valid;
  assign a_lt       = a_idx < b_idx;
  assign a_gt       = a_idx > b_idx;
  assign idx_eq     = both_valid & (a_idx == b_idx);
  assign pop_a      = a_ready & bus.a_valid;
  assign pop_b      = b_ready & bus.b_valid;
  // Done bits as they will stand after this cycle's pops.
  assign a_done_n   = a_done_q | (pop_a & bus.a_last);
  assign b_done_n   = b_done_q | (pop_b & bus.b_last);
  assign last_lat   = (cnt_q == '0);

  assign bus.a_ready = a_ready;
  assign bus.b_ready = b_ready;
  assign bus.mul_en  = mul_en;
  assign bus.add_en  = add_en;
  assign bus.mul_a   = mul_a_q;
  assign bus.mul_b   = mul_b_q;
  assign bus.add_a   = acc_q;
  assign bus.add_b   = prod_q;

  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign nan       = nan_q;
  assign zero      = zero_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (a_empty || b_empty) ? StFin : StMerge;
      StMerge: begin
        if (idx_eq)                   state_d = StMul;
        else if (a_done_n && b_done_n) state_d = StFin;
        else if (a_done_n || b_done_n) state_d = StDrain;
      end
      StDrain: if (a_done_n && b_done_n) state_d = StFin;
      StMul:   if (last_lat) state_d = StAdd;
      StAdd: begin
        if (last_lat) begin
          if (a_done_q && b_done_q)      state_d = StFin;
          else if (a_done_q || b_done_q) state_d = StDrain;
          else                           state_d = StMerge;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and clock-enable outputs decoded from the state.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    mul_en  = 1'b0;
    add_en  = 1'b0;
    busy    = (state_q != StIdle);
    unique case (state_q)
      StMerge: begin
        if (both_valid) begin
          a_ready = !a_gt;
          b_ready = !a_lt;
        end
      end
      StDrain: begin
        a_ready = !a_done_q;
        b_ready = a_done_q;
      end
      StMul:   mul_en = 1'b1;
      StAdd:   add_en = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operands, latency counter, accumulator, sticky flags and published result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      ovf_s_q  <= 1'b0;
      unf_s_q  <= 1'b0;
      nan_s_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      nan_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Registered so done lines up with the freshly published result.
      done_q <= (state_q == StFin);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc_q    <= '0;
            ovf_s_q  <= 1'b0;
            unf_s_q  <= 1'b0;
            nan_s_q  <= 1'b0;
            a_done_q <= a_empty;
            b_done_q <= b_empty;
          end
        end
        StMerge, StDrain: begin
          a_done_q <= a_done_n;
          b_done_q <= b_done_n;
          if (state_q == StMerge && idx_eq) begin
            mul_a_q <= bus.a_data;
            mul_b_q <= bus.b_data;
            cnt_q   <= MulLoad;
          end
        end
        StMul: begin
          if (last_lat) begin
            prod_q  <= bus.mul_result;
            ovf_s_q <= ovf_s_q | bus.mul_ovf;
            unf_s_q <= unf_s_q | bus.mul_unf;
            nan_s_q <= nan_s_q | bus.mul_nan;
            cnt_q   <= AddLoad;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StAdd: begin
          if (last_lat) begin
            acc_q   <= bus.add_result;
            ovf_s_q <= ovf_s_q | bus.add_ovf;
            unf_s_q <= unf_s_q | bus.add_unf;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFin: begin
          result_q <= acc_q;
          ovf_q    <= ovf_s_q;
          unf_q    <= unf_s_q;
          nan_q    <= nan_s_q;
          zero_q   <= (acc_q[14:0] == '0);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sparse_dot_sequencer.sv
// Bench for sparse_dot_sequencer: directed stream vectors, latency-exact mult/adder
// lookup models, and a done-triggered scoreboard monitor.
module tb_sparse_dot_sequencer;
  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned ADD_LAT = 7;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    logic        nan;
    logic        zero;
    int          busy_cyc;
    int          mul_cyc;
    int          add_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        a_empty = 1'b0;
  logic        b_empty = 1'b0;
  logic        busy, done, overflow, underflow, nan, zero;
  logic [15:0] result;

  sparse_dot_sequencer_if #(.IDX_W(8)) bus ();

  sparse_dot_sequencer #(
    .IDX_W  (8),
    .MUL_LAT(MUL_LAT),
    .ADD_LAT(ADD_LAT)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .a_empty  (a_empty),
    .b_empty  (b_empty),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .underflow(underflow),
    .nan      (nan),
    .zero     (zero),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   overlap = 0;

  logic [7:0]  a_idx_v[8];
  logic [15:0] a_dat_v[8];
  logic [7:0]  b_idx_v[8];
  logic [15:0] b_dat_v[8];
  int          na, nb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Hand-computed half-precision products: {nan, unf, ovf, result}.
  function automatic logic [18:0] mul_lut(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h4000, 16'h4200}: return {3'b000, 16'h4600};
      {16'h3C00, 16'h4000}: return {3'b000, 16'h4000};
      {16'h4000, 16'h4000}: return {3'b000, 16'h4400};
      {16'h7BFF, 16'h7BFF}: return {3'b001, 16'h7C00};
      default:              return {3'b100, 16'h7E00};
    endcase
  endfunction

  // Hand-computed half-precision sums: {unf, ovf, result}.
  function automatic logic [17:0] add_lut(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h0000, 16'h4600}: return {2'b00, 16'h4600};
      {16'h0000, 16'h4000}: return {2'b00, 16'h4000};
      {16'h4000, 16'h4400}: return {2'b00, 16'h4600};
      {16'h0000, 16'h7C00}: return {2'b00, 16'h7C00};
      default:              return {2'b11, 16'h7E00};
    endcase
  endfunction

  // Count consecutive enabled cycles; results are only valid on the last one.
  int mul_run, add_run;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_run <= 0;
      add_run <= 0;
    end else begin
      mul_run <= bus.mul_en ? mul_run + 1 : 0;
      add_run <= bus.add_en ? add_run + 1 : 0;
    end
  end

  always_comb begin
    bus.mul_result = 16'h0BAD;
    bus.mul_ovf    = 1'b0;
    bus.mul_unf    = 1'b0;
    bus.mul_nan    = 1'b0;
    if (bus.mul_en && mul_run == MUL_LAT - 1)
      {bus.mul_nan, bus.mul_unf, bus.mul_ovf, bus.mul_result} = mul_lut(bus.mul_a, bus.mul_b);
  end

  always_comb begin
    bus.add_result = 16'h0BAD;
    bus.add_ovf    = 1'b0;
    bus.add_unf    = 1'b0;
    if (bus.add_en && add_run == ADD_LAT - 1)
      {bus.add_unf, bus.add_ovf, bus.add_result} = add_lut(bus.add_a, bus.add_b);
  end

  // Monitor: counts activity per operation and scores each done pulse.
  int busy_cnt = 0;
  int mul_cnt = 0;
  int add_cnt = 0;
  always begin
    @(negedge clk);
    if (!rst_n) begin
      busy_cnt = 0;
      mul_cnt  = 0;
      add_cnt  = 0;
    end else begin
      if (busy) busy_cnt++;
      if (bus.mul_en) mul_cnt++;
      if (bus.add_en) add_cnt++;
      if (bus.mul_en && bus.add_en) overlap++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("overflow", 64'(overflow), 64'(e.ovf));
          check("underflow", 64'(underflow), 64'(e.unf));
          check("nan", 64'(nan), 64'(e.nan));
          check("zero", 64'(zero), 64'(e.zero));
          check("busy cycles", 64'(busy_cnt), 64'(e.busy_cyc));
          check("mul_en cycles", 64'(mul_cnt), 64'(e.mul_cyc));
          check("add_en cycles", 64'(add_cnt), 64'(e.add_cyc));
        end
        busy_cnt = 0;
        mul_cnt  = 0;
        add_cnt  = 0;
      end
    end
  end

  task automatic push_exp(input logic [15:0] res, input logic ovf, input logic zro,
                          input int bcyc, input int mcyc, input int acyc);
    exp_t e;
    e.res = res; e.ovf = ovf; e.unf = 1'b0; e.nan = 1'b0; e.zero = zro;
    e.busy_cyc = bcyc; e.mul_cyc = mcyc; e.add_cyc = acyc;
    exp_q.push_back(e);
  endtask

  task automatic set_a(input int i, input logic [7:0] idx, input logic [15:0] dat);
    a_idx_v[i] = idx;
    a_dat_v[i] = dat;
  endtask

  task automatic set_b(input int i, input logic [7:0] idx, input logic [15:0] dat);
    b_idx_v[i] = idx;
    b_dat_v[i] = dat;
  endtask

  task automatic start_op(input logic ae, input logic be);
    @(posedge clk); #1;
    start = 1'b1; a_empty = ae; b_empty = be;
    @(posedge clk); #1;
    start = 1'b0; a_empty = 1'b0; b_empty = 1'b0;
  endtask

  // Present each entry until the DUT accepts it; last is set on the final entry.
  task automatic drive(input bit is_a);
    int n;
    bit got;
    n = is_a ? na : nb;
    for (int i = 0; i < n; i++) begin
      if (is_a) begin
        bus.a_valid = 1'b1; bus.a_index = a_idx_v[i]; bus.a_data = a_dat_v[i];
        bus.a_last = (i == n - 1);
      end else begin
        bus.b_valid = 1'b1; bus.b_index = b_idx_v[i]; bus.b_data = b_dat_v[i];
        bus.b_last = (i == n - 1);
      end
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        got = is_a ? bus.a_ready : bus.b_ready;
        @(posedge clk); #1;
      end
      check(is_a ? "A entry consumed" : "B entry consumed", 64'(got), 64'd1);
    end
    if (is_a) bus.a_valid = 1'b0;
    else      bus.b_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done seen", 64'(seen), 64'd1);
  endtask

  task automatic run_op(input logic ae, input logic be);
    start_op(ae, be);
    fork
      drive(1'b1);
      drive(1'b0);
    join
    wait_done();
  endtask

  task automatic overflow_case();
    na = 1; nb = 1;
    set_a(0, 8'hFF, 16'h7BFF);
    set_b(0, 8'hFF, 16'h7BFF);
    push_exp(16'h7C00, 1'b1, 1'b0, 1 + MUL_LAT + ADD_LAT + 1, MUL_LAT, ADD_LAT);
    run_op(1'b0, 1'b0);
  endtask

  initial begin
    bit seen;
    bus.a_valid = 1'b0; bus.a_index = '0; bus.a_data = '0; bus.a_last = 1'b0;
    bus.b_valid = 1'b0; bus.b_index = '0; bus.b_data = '0; bus.b_last = 1'b0;
    #1;
    check("reset controls/flags", 64'({busy, done, bus.a_ready, bus.b_ready, bus.mul_en,
          bus.add_en, overflow, underflow, nan, zero, result}), 64'd0);
    check("reset operands", {bus.mul_a, bus.mul_b, bus.add_a, bus.add_b}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single match.
    na = 1; nb = 1;
    set_a(0, 8'd3, 16'h4000);
    set_b(0, 8'd3, 16'h4200);
    push_exp(16'h4600, 1'b0, 1'b0, 1 + MUL_LAT + ADD_LAT + 1, MUL_LAT, ADD_LAT);
    run_op(1'b0, 1'b0);

    // Disjoint: three merge pops, one drain pop, FIN.
    na = 2; nb = 2;
    set_a(0, 8'd1, 16'h3C00); set_a(1, 8'd4, 16'h3C00);
    set_b(0, 8'd2, 16'h4000); set_b(1, 8'd5, 16'h4000);
    push_exp(16'h0000, 1'b0, 1'b1, 5, 0, 0);
    run_op(1'b0, 1'b0);

    // Partial overlap; A entry 7 drained after B ends.
    na = 3; nb = 2;
    set_a(0, 8'd0, 16'h3C00); set_a(1, 8'd2, 16'h4000); set_a(2, 8'd7, 16'h4200);
    set_b(0, 8'd2, 16'h4200); set_b(1, 8'd3, 16'h3C00);
    push_exp(16'h4600, 1'b0, 1'b0, 2 + MUL_LAT + ADD_LAT + 3, MUL_LAT, ADD_LAT);
    run_op(1'b0, 1'b0);

    // Two matches: 1*2 + 2*2.
    na = 2; nb = 2;
    set_a(0, 8'd1, 16'h3C00); set_a(1, 8'd5, 16'h4000);
    set_b(0, 8'd1, 16'h4000); set_b(1, 8'd5, 16'h4000);
    push_exp(16'h4600, 1'b0, 1'b0, 2 * (1 + MUL_LAT + ADD_LAT) + 1, 2 * MUL_LAT, 2 * ADD_LAT);
    run_op(1'b0, 1'b0);

    // Overflow at the top index, then cleared by an empty-vector start.
    overflow_case();
    na = 0; nb = 0;
    push_exp(16'h0000, 1'b0, 1'b1, 1, 0, 0);
    run_op(1'b1, 1'b0);
    overflow_case();

    // Reset during MUL.
    na = 1; nb = 1;
    set_a(0, 8'd9, 16'h4000);
    set_b(0, 8'd9, 16'h4200);
    start_op(1'b0, 1'b0);
    fork
      drive(1'b1);
      drive(1'b0);
    join
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (bus.mul_en) seen = 1'b1;
    end
    check("mul_en reached", 64'(seen), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async reset controls/flags", 64'({busy, done, bus.a_ready, bus.b_ready, bus.mul_en,
          bus.add_en, overflow, underflow, nan, zero, result}), 64'd0);
    check("async reset operands", {bus.mul_a, bus.mul_b, bus.add_a, bus.add_b}, 64'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    push_exp(16'h4600, 1'b0, 1'b0, 1 + MUL_LAT + ADD_LAT + 1, MUL_LAT, ADD_LAT);
    run_op(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("mul_en/add_en overlap cycles", 64'(overlap), 64'd0);
    check("pending expectations", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
